// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_pkg
// Brief    : Opcode/ALUControl encodings and control-word layout for the
//            group processor's pipelined control unit.
// Revision : 1.0
// ============================================================================
package control_pkg;

    localparam logic [4:0] OP_MOD  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_MUL  = 5'b00100;
    localparam logic [4:0] OP_CNB  = 5'b00101;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BGT  = 5'b01001;
    localparam logic [4:0] OP_ADDI = 5'b10000;
    localparam logic [4:0] OP_SRL  = 5'b10001;
    localparam logic [4:0] OP_SLL  = 5'b10010;
    localparam logic [4:0] OP_SB   = 5'b10011;
    localparam logic [4:0] OP_LB   = 5'b10100;
    localparam logic [4:0] OP_LW   = 5'b10101;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_MOD = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_CNB = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;

    typedef struct packed {
        logic regw;
        logic alusrc;
        logic branch;
        logic memw;
        logic memtoreg;
        logic imm;
    } ctrl_word_t;

endpackage
`default_nettype wire

// File: rtl/control_decoder.sv
`default_nettype none
// ============================================================================
// Module   : control_decoder
// Brief    : Combinational opcode decode to ALUControl, control word,
//            multi-cycle flag and illegal-opcode flag.
// Revision : 1.0
// ============================================================================
module control_decoder
    import control_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] i_opcode,
    output logic [3:0]     o_aluctl,
    output ctrl_word_t     o_cw,
    output logic           o_is_multi,
    output logic           o_illegal
);

    localparam ctrl_word_t c_cw_alu  = 6'b100000;
    localparam ctrl_word_t c_cw_beq  = 6'b001001;
    localparam ctrl_word_t c_cw_bgt  = 6'b001000;
    localparam ctrl_word_t c_cw_addi = 6'b110001;
    localparam ctrl_word_t c_cw_sb   = 6'b010101;
    localparam ctrl_word_t c_cw_load = 6'b110011;

    logic [4:0] w_op5;
    logic       w_upper_nz;

    // Wider opcodes with any bit above bit 4 set are undefined.
    generate
        if (OPW > 5) begin : g_wide
            assign w_op5      = i_opcode[4:0];
            assign w_upper_nz = |i_opcode[OPW-1:5];
        end else begin : g_narrow
            assign w_op5      = 5'(i_opcode);
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        o_aluctl   = ALU_ADD;
        o_cw       = '0;
        o_is_multi = 1'b0;
        o_illegal  = 1'b0;
        case (w_op5)
            OP_MOD:  begin o_aluctl = ALU_MOD; o_cw = c_cw_alu; o_is_multi = 1'b1; end
            OP_ADD:  begin o_aluctl = ALU_ADD; o_cw = c_cw_alu;  end
            OP_AND:  begin o_aluctl = ALU_AND; o_cw = c_cw_alu;  end
            OP_SUB:  begin o_aluctl = ALU_SUB; o_cw = c_cw_alu;  end
            OP_MUL:  begin o_aluctl = ALU_MUL; o_cw = c_cw_alu; o_is_multi = 1'b1; end
            OP_CNB:  begin o_aluctl = ALU_CNB; o_cw = c_cw_alu;  end
            OP_BEQ:  begin o_aluctl = ALU_ADD; o_cw = c_cw_beq;  end
            OP_BGT:  begin o_aluctl = ALU_ADD; o_cw = c_cw_bgt;  end
            OP_ADDI: begin o_aluctl = ALU_ADD; o_cw = c_cw_addi; end
            OP_SRL:  begin o_aluctl = ALU_SRL; o_cw = c_cw_alu;  end
            OP_SLL:  begin o_aluctl = ALU_SLL; o_cw = c_cw_alu;  end
            OP_SB:   begin o_aluctl = ALU_ADD; o_cw = c_cw_sb;   end
            OP_LB:   begin o_aluctl = ALU_ADD; o_cw = c_cw_load; end
            OP_LW:   begin o_aluctl = ALU_ADD; o_cw = c_cw_load; end
            default: o_illegal = 1'b1;
        endcase
        if (w_upper_nz) begin
            o_aluctl   = ALU_ADD;
            o_cw       = '0;
            o_is_multi = 1'b0;
            o_illegal  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_pipe
// Brief    : Pipelined control unit: decode into EX, then MEM and WB copies,
//            with multi-cycle MUL/MOD hold, stall, flush and illegal detect.
// Revision : 1.0
// ============================================================================
module control_unit_pipe
    import control_pkg::*;
#(
    parameter int OPW        = 5,
    parameter int ALUCW      = 4,
    parameter int MUL_CYCLES = 3,
    parameter int MOD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [OPW-1:0]   opcode_i,
    output logic             ready_o,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             ex_valid_o,
    output logic [ALUCW-1:0] ex_aluctl_o,
    output logic             ex_regw_o,
    output logic             ex_alusrc_o,
    output logic             ex_branch_o,
    output logic             ex_memw_o,
    output logic             ex_memtoreg_o,
    output logic             ex_imm_o,
    output logic             mem_valid_o,
    output logic             mem_regw_o,
    output logic             mem_memw_o,
    output logic             mem_memtoreg_o,
    output logic             wb_valid_o,
    output logic             wb_regw_o,
    output logic             wb_memtoreg_o,
    output logic             busy_o,
    output logic             illegal_o
);

    localparam int c_max_cycles = (MUL_CYCLES > MOD_CYCLES) ? MUL_CYCLES : MOD_CYCLES;
    localparam int c_cntw       = $clog2(c_max_cycles + 1);

    localparam logic [c_cntw-1:0] c_mul_load = c_cntw'(MUL_CYCLES - 1);
    localparam logic [c_cntw-1:0] c_mod_load = c_cntw'(MOD_CYCLES - 1);
    localparam logic [c_cntw-1:0] c_cnt_one  = c_cntw'(1);

    localparam logic [0:0] c_st_run   = 1'b0;
    localparam logic [0:0] c_st_multi = 1'b1;

    logic [3:0]        w_dec_alu;
    ctrl_word_t        w_dec_cw;
    logic              w_dec_multi;
    logic              w_dec_illegal;
    logic              w_accept;
    logic              w_flush;
    logic              w_in_multi;
    logic [c_cntw-1:0] w_multi_load;
    logic              w_go_multi;

    logic [0:0]        r_state;
    logic [c_cntw-1:0] r_cnt;
    logic              r_flush_pend;
    logic              r_illegal;
    logic              r_ex_valid;
    logic [ALUCW-1:0]  r_ex_alu;
    ctrl_word_t        r_ex_cw;
    logic              r_mem_valid;
    logic              r_mem_regw;
    logic              r_mem_memw;
    logic              r_mem_memtoreg;
    logic              r_wb_valid;
    logic              r_wb_regw;
    logic              r_wb_memtoreg;

    control_decoder #(
        .OPW (OPW)
    ) u_decoder (
        .i_opcode   (opcode_i),
        .o_aluctl   (w_dec_alu),
        .o_cw       (w_dec_cw),
        .o_is_multi (w_dec_multi),
        .o_illegal  (w_dec_illegal)
    );

    assign w_in_multi   = (r_state == c_st_multi);
    assign ready_o      = !stall_i && !w_in_multi;
    assign w_accept     = valid_i && ready_o;
    assign w_flush      = flush_i || r_flush_pend;
    assign w_multi_load = (w_dec_alu == ALU_MOD) ? c_mod_load : c_mul_load;
    // A one-cycle multi-cycle op loads a zero count and never leaves RUN.
    assign w_go_multi   = w_dec_multi && (w_multi_load != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_run;
            r_cnt          <= '0;
            r_flush_pend   <= 1'b0;
            r_illegal      <= 1'b0;
            r_ex_valid     <= 1'b0;
            r_ex_alu       <= '0;
            r_ex_cw        <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_regw     <= 1'b0;
            r_mem_memw     <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_regw      <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
        end else if (stall_i) begin
            // Everything freezes; a flush seen now is applied once the stall lifts.
            r_flush_pend <= r_flush_pend || flush_i;
        end else begin
            r_flush_pend  <= 1'b0;
            r_illegal     <= w_accept && w_dec_illegal;
            r_wb_valid    <= r_mem_valid;
            r_wb_regw     <= r_mem_regw;
            r_wb_memtoreg <= r_mem_memtoreg;

            if (w_in_multi || w_flush) begin
                r_mem_valid    <= 1'b0;
                r_mem_regw     <= 1'b0;
                r_mem_memw     <= 1'b0;
                r_mem_memtoreg <= 1'b0;
            end else begin
                r_mem_valid    <= r_ex_valid;
                r_mem_regw     <= r_ex_cw.regw;
                r_mem_memw     <= r_ex_cw.memw;
                r_mem_memtoreg <= r_ex_cw.memtoreg;
            end

            if (w_accept) begin
                r_ex_valid <= !w_dec_illegal;
                r_ex_alu   <= ALUCW'(w_dec_alu);
                r_ex_cw    <= w_dec_cw;
                r_state    <= w_go_multi ? c_st_multi : c_st_run;
                r_cnt      <= w_go_multi ? w_multi_load : '0;
            end else if (w_flush || !w_in_multi) begin
                r_ex_valid <= 1'b0;
                r_ex_alu   <= '0;
                r_ex_cw    <= '0;
                r_state    <= c_st_run;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    r_state <= c_st_run;
                end
            end
        end
    end

    assign ex_valid_o     = r_ex_valid;
    assign ex_aluctl_o    = r_ex_alu;
    assign ex_regw_o      = r_ex_cw.regw;
    assign ex_alusrc_o    = r_ex_cw.alusrc;
    assign ex_branch_o    = r_ex_cw.branch;
    assign ex_memw_o      = r_ex_cw.memw;
    assign ex_memtoreg_o  = r_ex_cw.memtoreg;
    assign ex_imm_o       = r_ex_cw.imm;
    assign mem_valid_o    = r_mem_valid;
    assign mem_regw_o     = r_mem_regw;
    assign mem_memw_o     = r_mem_memw;
    assign mem_memtoreg_o = r_mem_memtoreg;
    assign wb_valid_o     = r_wb_valid;
    assign wb_regw_o      = r_wb_regw;
    assign wb_memtoreg_o  = r_wb_memtoreg;
    assign busy_o         = w_in_multi;
    assign illegal_o      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_control_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit_pipe
// Brief    : Directed and randomized bench for control_unit_pipe against an
//            occupancy-based reference model.
// Revision : 1.0
// ============================================================================
module tb_control_unit_pipe;

    localparam int OPW        = 5;
    localparam int ALUCW      = 4;
    localparam int MUL_CYCLES = 3;
    localparam int MOD_CYCLES = 8;

    logic             clk = 1'b0;
    logic             rst, valid_i, stall_i, flush_i;
    logic [OPW-1:0]   opcode_i;
    logic             ready_o, ex_valid_o, ex_regw_o, ex_alusrc_o, ex_branch_o;
    logic             ex_memw_o, ex_memtoreg_o, ex_imm_o;
    logic [ALUCW-1:0] ex_aluctl_o;
    logic             mem_valid_o, mem_regw_o, mem_memw_o, mem_memtoreg_o;
    logic             wb_valid_o, wb_regw_o, wb_memtoreg_o, busy_o, illegal_o;

    control_unit_pipe #(
        .OPW(OPW), .ALUCW(ALUCW), .MUL_CYCLES(MUL_CYCLES), .MOD_CYCLES(MOD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i), .ready_o(ready_o),
        .stall_i(stall_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o),
        .ex_aluctl_o(ex_aluctl_o), .ex_regw_o(ex_regw_o), .ex_alusrc_o(ex_alusrc_o),
        .ex_branch_o(ex_branch_o), .ex_memw_o(ex_memw_o), .ex_memtoreg_o(ex_memtoreg_o),
        .ex_imm_o(ex_imm_o), .mem_valid_o(mem_valid_o), .mem_regw_o(mem_regw_o),
        .mem_memw_o(mem_memw_o), .mem_memtoreg_o(mem_memtoreg_o), .wb_valid_o(wb_valid_o),
        .wb_regw_o(wb_regw_o), .wb_memtoreg_o(wb_memtoreg_o), .busy_o(busy_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    logic [9:0] ex_word;
    assign ex_word = {ex_aluctl_o, ex_regw_o, ex_alusrc_o, ex_branch_o,
                      ex_memw_o, ex_memtoreg_o, ex_imm_o};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decode table, indexed by opcode.
    logic [3:0] t_alu [32];
    logic [5:0] t_cw  [32];
    logic       t_ok  [32];
    int         t_cyc [32];
    logic [4:0] legal_ops [14];

    task automatic def(input int idx, input logic [4:0] op, input logic [3:0] alu,
                       input logic [5:0] cw, input int cyc);
        t_alu[op] = alu; t_cw[op] = cw; t_ok[op] = 1'b1; t_cyc[op] = cyc;
        legal_ops[idx] = op;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            t_alu[i] = '0; t_cw[i] = '0; t_ok[i] = 1'b0; t_cyc[i] = 0;
        end
        def(0,  5'b00000, 4'b0011, 6'b100000, MOD_CYCLES);
        def(1,  5'b00001, 4'b0000, 6'b100000, 1);
        def(2,  5'b00010, 4'b0100, 6'b100000, 1);
        def(3,  5'b00011, 4'b0001, 6'b100000, 1);
        def(4,  5'b00100, 4'b0010, 6'b100000, MUL_CYCLES);
        def(5,  5'b00101, 4'b0101, 6'b100000, 1);
        def(6,  5'b01000, 4'b0000, 6'b001001, 1);
        def(7,  5'b01001, 4'b0000, 6'b001000, 1);
        def(8,  5'b10000, 4'b0000, 6'b110001, 1);
        def(9,  5'b10001, 4'b1000, 6'b100000, 1);
        def(10, 5'b10010, 4'b1001, 6'b100000, 1);
        def(11, 5'b10011, 4'b0000, 6'b010101, 1);
        def(12, 5'b10100, 4'b0000, 6'b110011, 1);
        def(13, 5'b10101, 4'b0000, 6'b110011, 1);
    end

    // Model: m_occ = cycles the EX instruction still needs in EX (0 = bubble).
    logic       model_on = 1'b0;
    logic       m_ex_v, m_mem_v, m_wb_v, m_ill, m_pend;
    logic [3:0] m_ex_alu;
    logic [5:0] m_ex_cw, m_mem_cw, m_wb_cw;
    int         m_occ;

    always @(posedge clk) begin
        logic acc, fl;
        if (rst) begin
            model_on = 1'b1;
            m_ex_v = 0; m_mem_v = 0; m_wb_v = 0; m_ill = 0; m_pend = 0;
            m_ex_alu = 0; m_ex_cw = 0; m_mem_cw = 0; m_wb_cw = 0; m_occ = 0;
        end else if (stall_i) begin
            m_pend = m_pend || flush_i;
        end else begin
            acc    = valid_i && (m_occ <= 1);
            fl     = flush_i || m_pend;
            m_pend = 1'b0;
            m_wb_v = m_mem_v; m_wb_cw = m_mem_cw;
            if (m_ex_v && m_occ <= 1 && !fl) begin
                m_mem_v = 1'b1; m_mem_cw = m_ex_cw;
            end else begin
                m_mem_v = 1'b0; m_mem_cw = '0;
            end
            m_ill = acc && !t_ok[opcode_i];
            if (acc) begin
                m_ex_v   = t_ok[opcode_i];
                m_ex_alu = t_alu[opcode_i];
                m_ex_cw  = t_cw[opcode_i];
                m_occ    = t_cyc[opcode_i];
            end else if (!fl && m_occ > 1) begin
                m_occ = m_occ - 1;
            end else begin
                m_ex_v = 0; m_ex_alu = 0; m_ex_cw = 0; m_occ = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("ready",   ready_o,    (!stall_i && m_occ <= 1));
            chk("busy",    busy_o,     (m_occ > 1));
            chk("illegal", illegal_o,  m_ill);
            chk("ex",      {ex_valid_o, ex_word}, {m_ex_v, m_ex_alu, m_ex_cw});
            chk("mem",     {mem_valid_o, mem_regw_o, mem_memw_o, mem_memtoreg_o},
                           {m_mem_v, m_mem_cw[5], m_mem_cw[2], m_mem_cw[1]});
            chk("wb",      {wb_valid_o, wb_regw_o, wb_memtoreg_o},
                           {m_wb_v, m_wb_cw[5], m_wb_cw[1]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic st, input logic fl);
        valid_i = v; opcode_i = op; stall_i = st; flush_i = fl;
    endtask

    task automatic idle(input int n);
        drive(0, 5'b00001, 0, 0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        drive(0, 5'b00000, 0, 0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_state", {ex_valid_o, ex_word, mem_valid_o, wb_valid_o, busy_o, illegal_o}, 0);

        // ADD, LW, SB back-to-back
        drive(1, 5'b00001, 0, 0); cyc();
        chk("ex_add", {ex_valid_o, ex_word}, {1'b1, 10'b0000_100000});
        drive(1, 5'b10101, 0, 0); cyc();
        chk("ex_lw", ex_word, 10'b0000_110011);
        drive(1, 5'b10011, 0, 0); cyc();
        chk("ex_sb", ex_word, 10'b0000_010101);
        chk("mem_lw", {mem_valid_o, mem_memtoreg_o}, 2'b11);
        drive(0, 5'b00001, 0, 0); cyc();
        chk("wb_lw", {wb_valid_o, wb_memtoreg_o}, 2'b11);
        chk("mem_sb", {mem_valid_o, mem_memw_o}, 2'b11);
        idle(3);

        // MUL hold, then ADD accepted in the final EX cycle
        drive(1, 5'b00100, 0, 0); cyc();
        drive(1, 5'b00001, 0, 0); #1;
        chk("mul_c1", {busy_o, ready_o, ex_aluctl_o}, {2'b10, 4'b0010});
        cyc();
        chk("mul_c2", {busy_o, ready_o, ex_aluctl_o}, {2'b10, 4'b0010});
        cyc();
        chk("mul_c3", {busy_o, ready_o, ex_aluctl_o}, {2'b01, 4'b0010});
        cyc();
        chk("mul_mem", {mem_valid_o, mem_regw_o, ex_valid_o, ex_aluctl_o}, {3'b111, 4'b0000});
        idle(4);

        // Illegal opcode
        drive(1, 5'b11111, 0, 0); cyc();
        chk("ill_pulse", {illegal_o, ex_valid_o, ex_regw_o}, 3'b100);
        drive(0, 5'b00001, 0, 0); cyc();
        chk("ill_after", {illegal_o, mem_valid_o, mem_regw_o}, 3'b000);
        cyc();
        chk("ill_wb", {wb_valid_o, wb_regw_o}, 2'b00);
        idle(2);

        // BEQ flushed while ADDI is accepted
        drive(1, 5'b01000, 0, 0); cyc();
        chk("ex_beq", ex_word, 10'b0000_001001);
        drive(1, 5'b10000, 0, 1); cyc();
        chk("flush_ex", {ex_valid_o, ex_word}, {1'b1, 10'b0000_110001});
        chk("flush_mem", mem_valid_o, 0);
        drive(0, 5'b00001, 0, 0); cyc();
        chk("addi_mem", {mem_valid_o, mem_regw_o}, 2'b11);
        idle(3);

        // Modulo op with a 5-cycle stall inside the hold: MEM arrives 5 cycles late
        drive(1, 5'b00000, 0, 0); cyc();
        n = 1;
        while (!mem_valid_o && n < 40) begin
            drive(0, 5'b00001, (n >= 3 && n <= 7), 0);
            if (n == 7) chk("mod_frozen", {busy_o, ex_aluctl_o}, {1'b1, 4'b0011});
            cyc();
            n++;
        end
        chk("mod_latency", n, MOD_CYCLES + 1 + 5);
        idle(3);

        // Reset in the middle of a MOD hold
        drive(1, 5'b00000, 0, 0); cyc();
        drive(0, 5'b00001, 0, 0); cyc(); cyc(); cyc();
        chk("mod_busy", busy_o, 1);
        rst = 1'b1; cyc();
        rst = 1'b0; #1;
        chk("rst_mid", {ex_valid_o, ex_word, mem_valid_o, wb_valid_o, busy_o, illegal_o, ready_o},
            {16'b0, 1'b1});
        cyc();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [4:0] op;
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 13)];
            else op = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 3) != 0), op, ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 11) == 0));
            cyc();
        end
        rst = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
